// File: rtl/microc_pkg.sv
// Shared encodings for the microc core: PC operations and ALU operations.
// Control unit, PC unit and testbenches all import this package.
package microc_pkg;

    localparam logic [2:0] OP_INC  = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JZ   = 3'b010;
    localparam logic [2:0] OP_JNZ  = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;
    localparam logic [2:0] OP_HOLD = 3'b110;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_PASS = 3'b101;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. The top entry is read combinationally from the
// registered stack pointer, so a pop can follow a push with no bubble.
module ret_stack #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               top,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       full,
    output logic                       empty
);

    localparam int SP_W = $clog2(DEPTH + 1);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]    r_mem [2**AW];
    logic [SP_W-1:0] r_sp;
    logic [SP_W-1:0] w_sp_dec;
    logic            w_do_push;
    logic            w_do_pop;

    assign w_sp_dec  = r_sp - SP_W'(1);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sp <= '0;
        end else if (w_do_push) begin
            r_sp <= r_sp + SP_W'(1);
        end else if (w_do_pop) begin
            r_sp <= w_sp_dec;
        end
    end

    // NOTE: storage is deliberately not reset; contents are only read below a valid sp.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_sp[AW-1:0]] <= din;
        end
    end

    assign top   = r_mem[w_sp_dec[AW-1:0]];
    assign sp    = r_sp;
    assign full  = (r_sp == SP_W'(DEPTH));
    assign empty = (r_sp == '0);

endmodule

// File: rtl/pc_call_unit.sv
// Program-counter unit with jump, conditional jump, call and return.
// Stack overflow/underflow vectors to TRAP_VEC and sets a sticky error flag.
module pc_call_unit
    import microc_pkg::*;
#(
    parameter int              PC_W      = 10,
    parameter int              DEPTH     = 4,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter logic [PC_W-1:0] TRAP_VEC  = '1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 pc_op,
    input  logic [PC_W-1:0]            target,
    input  logic                       z,
    input  logic                       stall,
    output logic [PC_W-1:0]            pc,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf_err,
    output logic                       unf_err
);

    logic [PC_W-1:0] r_pc;
    logic            r_ovf_err;
    logic            r_unf_err;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_top;
    logic            w_full;
    logic            w_empty;
    logic            w_is_call;
    logic            w_is_ret;
    logic            w_push;
    logic            w_pop;
    logic            w_ovf;
    logic            w_unf;

    assign w_pc_inc  = r_pc + PC_W'(1);
    assign w_is_call = (pc_op == OP_CALL);
    assign w_is_ret  = (pc_op == OP_RET);
    assign w_push    = !stall && w_is_call && !w_full;
    assign w_pop     = !stall && w_is_ret && !w_empty;
    assign w_ovf     = !stall && w_is_call && w_full;
    assign w_unf     = !stall && w_is_ret && w_empty;

    ret_stack #(
        .W     (PC_W),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_pc_inc),
        .top   (w_top),
        .sp    (sp),
        .full  (w_full),
        .empty (w_empty)
    );

    // NOTE: default assignment first so no path through the case can infer a latch.
    always_comb begin
        w_pc_next = w_pc_inc;
        case (pc_op)
            OP_JMP:  w_pc_next = target;
            OP_JZ:   w_pc_next = z ? target : w_pc_inc;
            OP_JNZ:  w_pc_next = z ? w_pc_inc : target;
            OP_CALL: w_pc_next = w_full ? TRAP_VEC : target;
            OP_RET:  w_pc_next = w_empty ? TRAP_VEC : w_top;
            OP_HOLD: w_pc_next = r_pc;
            default: w_pc_next = w_pc_inc;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc      <= RESET_VEC;
            r_ovf_err <= 1'b0;
            r_unf_err <= 1'b0;
        end else begin
            if (!stall) begin
                r_pc <= w_pc_next;
            end
            if (w_ovf) begin
                r_ovf_err <= 1'b1;
            end
            if (w_unf) begin
                r_unf_err <= 1'b1;
            end
        end
    end

    assign pc      = r_pc;
    assign full    = w_full;
    assign empty   = w_empty;
    assign ovf_err = r_ovf_err;
    assign unf_err = r_unf_err;

endmodule

// File: doc/pc_call_unit.md
Name: pc_call_unit

Overview:
Parametrised next-generation program-counter unit for the microc core. It replaces the fixed increment/immediate PC multiplexer (s_inc) with an encoded PC operation: increment, jump, conditional jump on the zero flag, subroutine call and return. Call and return use an internal LIFO return-address stack with trap handling on overflow and underflow. It sits between the control unit (pc_op, stall) and program memory (pc), and takes z from the datapath zero-flag register.

Parameters:
PC_W, 10, program-counter and address width in bits.
DEPTH, 4, number of return-address stack entries (>=1).
RESET_VEC, 0, PC value loaded on reset.
TRAP_VEC, 2**PC_W-1, PC value loaded on a stack overflow or underflow.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
pc_op  input  3  operation: 000 INC, 001 JMP, 010 JZ, 011 JNZ, 100 CALL, 101 RET, 110 HOLD, 111 reserved.
target  input  PC_W  jump/call destination.
z  input  1  zero flag from the datapath.
stall  input  1  freezes all state when 1.
pc  output  PC_W  current program counter.
sp  output  $clog2(DEPTH+1)  number of valid stack entries.
full  output  1  sp == DEPTH (combinational from sp).
empty  output  1  sp == 0 (combinational from sp).
ovf_err  output  1  sticky: CALL was issued while full.
unf_err  output  1  sticky: RET was issued while empty.

Behaviour:
- Reset (async, active-high): pc=RESET_VEC, sp=0, ovf_err=0, unf_err=0. Stack contents are don't-care.
- All updates are registered. The new pc is visible one cycle after the op is sampled. There is no combinational path from pc_op, target, z or stall to any output.
- stall=1: pc, sp, stack contents and error flags hold, whatever pc_op is.
- pc+1 is computed modulo 2**PC_W, so 2**PC_W-1 wraps to 0.
- INC: pc<=pc+1.
- JMP: pc<=target.
- JZ: pc<=target if z=1, else pc+1.
- JNZ: pc<=target if z=0, else pc+1.
- CALL, not full: stack[sp]<=pc+1, sp<=sp+1, pc<=target.
- CALL, full: no push, sp unchanged, ovf_err<=1, pc<=TRAP_VEC.
- RET, not empty: pc<=stack[sp-1], sp<=sp-1.
- RET, empty: sp stays 0, unf_err<=1, pc<=TRAP_VEC.
- HOLD: all state unchanged.
- 111 (reserved): behaves exactly as INC.
- Error flags stay set until reset. A set flag does not block later operations.
- Back-to-back CALL/RET in consecutive cycles must work with no bubble; the stack read uses the registered sp.
- A call nested DEPTH deep succeeds; call DEPTH+1 traps.
- Reset asserted mid-operation overrides any op in flight and clears the stack pointer.

Decomposition:
- Shared package microc_pkg holds the pc_op encodings as localparams (OP_INC, OP_JMP, OP_JZ, OP_JNZ, OP_CALL, OP_RET, OP_HOLD). The ALUOp encodings move there as well, so the control unit and the bench share one definition.
- One sub-module, ret_stack: parametrised LIFO (width PC_W, DEPTH) with push, pop, top, sp, full and empty, plus the same clk and reset.
- pc_call_unit holds the pc register, the next-pc mux and the error flags.

Test Plan:
1. Reset, then INC for 3 cycles -> pc 0,1,2,3; sp=0; empty=1; both error flags 0.
2. JMP target=1022, then INC twice -> pc 1022, 1023, 0 (wrap-around).
3. From pc=5: JZ target=40 with z=0 -> pc=6; then JZ target=40 with z=1 -> pc=40; then JNZ target=7 with z=1 -> pc=41.
4. From pc=10: CALL 100, CALL 200, RET, RET -> pc 100 (sp=1), 200 (sp=2), 101 (sp=1), 11 (sp=0, empty=1).
5. Four nested CALLs from pc=0 -> sp=4, full=1; fifth CALL -> pc=1023, ovf_err=1, sp=4. Four RETs then unwind to the stored return addresses. A fifth RET -> pc=1023, unf_err=1. Both flags remain 1 until reset.
6. Hold stall=1 for 3 cycles during CALL and RET -> pc and sp unchanged. Assert reset asynchronously mid-cycle with sp=2 -> pc=0, sp=0 and both errors 0 immediately, without waiting for a clock edge.
